alu_issue: RTL

Two-stage issue/writeback stage sitting directly upstream of the 8-bit `alu`. It accepts register-based instructions over a valid/ready handshake and reads operands from a 4-entry register file, forwarding from the instruction in flight. It drives the ALU's `A`/`B`/`alu_op` from a registered execute stage, then captures `Y`/`zero_flag` into a writeback register that streams results out and updates the register file.

---
 rtl/alu_issue.sv | 107 ++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the 8-bit ALU: operand read with forwarding
// from the execute register, registered ALU drive, and a writeback register that streams results out.
module alu_issue #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int NREG   = 4,
    localparam int RW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [RW-1:0]     in_rd,
    input  logic [RW-1:0]     in_rs1,
    input  logic [RW-1:0]     in_rs2,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [RW-1:0]     wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero
);

    logic              r_ex_valid;
    logic [RW-1:0]     r_ex_rd;
    logic [DATA_W-1:0] r_alu_a, r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic              r_wb_valid;
    logic [RW-1:0]     r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_wb_zero;
    logic [DATA_W-1:0] r_rf [NREG];

    logic              w_advance;
    logic              w_accept;
    logic              w_rf_we;
    logic [DATA_W-1:0] w_opa, w_opb;

    // The whole pipe moves as one: a stalled writeback freezes EX and the register file too.
    assign w_advance = !r_wb_valid || wb_ready;
    assign w_accept  = in_valid && w_advance;
    assign w_rf_we   = w_advance && r_ex_valid && (r_ex_rd != '0);
    assign in_ready  = w_advance;

    always_comb begin
        w_opa = '0;
        w_opb = '0;
        if (in_rs1 != '0)
            w_opa = (r_ex_valid && r_ex_rd == in_rs1) ? alu_y : r_rf[in_rs1];
        if (in_rs2 != '0)
            w_opb = (r_ex_valid && r_ex_rd == in_rs2) ? alu_y : r_rf[in_rs2];
        if (in_imm_en)
            w_opb = in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_wb_zero  <= 1'b0;
        end else if (w_advance) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_ex_rd  <= in_rd;
                r_alu_a  <= w_opa;
                r_alu_b  <= w_opb;
                r_alu_op <= in_op;
            end
            r_wb_valid <= r_ex_valid;
            r_wb_rd    <= r_ex_rd;
            r_wb_data  <= alu_y;
            r_wb_zero  <= alu_zero;
        end
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
            for (int i = 1; i < NREG; i++)
                if (r_ex_rd == RW'(i)) r_rf[i] <= alu_y;
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_op   = r_alu_op;
    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_data  = r_wb_data;
    assign wb_zero  = r_wb_zero;

endmodule
